parking_timer: RTL and testbench

PARKING_TIMER -- requirements
Module: parking_timer

---
 rtl/parking_timer_pkg.sv | 39 +++
 rtl/parking_timer_if.sv | 32 +++
 rtl/parking_timer_tick_sync_edge.sv | 53 +++++
 rtl/parking_timer.sv | 178 +++++++++++++++++
 tb/tb_parking_timer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_timer_pkg.sv
// parking_timer_pkg: shared types and constants for the parking timer.
//   state_e         : FSM state encoding (IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3)
//   MIN_W / SEC_W   : widths of the elapsed minutes (7) and seconds (6) counters
//   SECONDS_PER_MIN : seconds wrap point (60)
//   elapsed_inc()   : one-second increment of a {min,sec} pair (no saturation)
package parking_timer_pkg;

    localparam int MIN_W           = 7;
    localparam int SEC_W           = 6;
    localparam int SECONDS_PER_MIN = 60;

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECONDS_PER_MIN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } elapsed_t;

    // Advance a time value by one second; seconds wrap 59 -> 0 and carry into minutes.
    function automatic elapsed_t elapsed_inc(input elapsed_t t);
        elapsed_t r;
        if (t.sec == SEC_LAST) begin
            r.min = t.min + MIN_W'(1);
            r.sec = SEC_W'(0);
        end else begin
            r.min = t.min;
            r.sec = t.sec + SEC_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/parking_timer_if.sv
// parking_timer_if: bundle of the parking timer's tick, command, limit and
// status signals. Clock and reset stay outside the bundle.
//   master modport : drives ticks, commands and limits; observes status
//   slave  modport : the timer side (receives ticks/commands, drives status)
interface parking_timer_if;
    import parking_timer_pkg::*;

    logic             tick_1hz_in;
    logic             tick_2hz_in;
    logic             start;
    logic             stop;
    logic             clear;
    logic [MIN_W-1:0] limit_min;
    logic [SEC_W-1:0] limit_sec;
    logic [MIN_W-1:0] elapsed_min;
    logic [SEC_W-1:0] elapsed_sec;
    logic [1:0]       state;
    logic             sec_strobe;
    logic             expired;
    logic             blink;

    modport master (
        output tick_1hz_in, tick_2hz_in, start, stop, clear, limit_min, limit_sec,
        input  elapsed_min, elapsed_sec, state, sec_strobe, expired, blink
    );

    modport slave (
        input  tick_1hz_in, tick_2hz_in, start, stop, clear, limit_min, limit_sec,
        output elapsed_min, elapsed_sec, state, sec_strobe, expired, blink
    );

endinterface

// File: rtl/parking_timer_tick_sync_edge.sv
// tick_sync_edge: brings an asynchronous tick square wave into the clk domain
// and emits a one-cycle strobe per rising edge.
//   clk, reset_n : system clock, asynchronous active-low reset
//   tick_in      : asynchronous square wave
//   strobe       : registered pulse, SYNC_STAGES+1 cycles after the input edge
// Strobes are masked for SYNC_STAGES+1 cycles after reset release so that a
// tick which is already high when reset lifts is not mistaken for an edge.
module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_in,
    output logic strobe
);

    localparam logic [2:0] SUP_LOAD = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [2:0]             sup_q, sup_d;
    logic                   strobe_q, strobe_d;

    // Next-state: shift the synchronizer, detect a rising edge, count down the mask.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], tick_in};
        prev_d   = sync_q[SYNC_STAGES-1];
        strobe_d = sync_q[SYNC_STAGES-1] & ~prev_q & (sup_q == 3'd0);
        if (sup_q != 3'd0) begin
            sup_d = sup_q - 3'd1;
        end else begin
            sup_d = sup_q;
        end
    end

    // State registers; the mask counter reloads on every reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= {SYNC_STAGES{1'b0}};
            prev_q   <= 1'b0;
            sup_q    <= SUP_LOAD;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            sup_q    <= sup_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/parking_timer.sv
// parking_timer: elapsed-time counter for a parking meter with an optional
// expiry limit.
//   clk, reset_n              : system clock, asynchronous active-low reset
//   tick_1hz_in / tick_2hz_in : divider square waves (2 Hz only drives blink)
//   start / stop / clear      : one-cycle commands, priority clear > stop > start
//   limit_min / limit_sec     : expiry limit, 0:00 means no limit
//   elapsed_min / elapsed_sec : running count
//   state                     : IDLE=0 RUNNING=1 PAUSED=2 EXPIRED=3
//   sec_strobe                : one pulse per 1 Hz rising edge, in any state
//   expired                   : high while in EXPIRED
//   blink                     : 1 Hz expiry flasher when PARKING_TIMER_BLINK_EN
//                               is defined, constant 0 otherwise
module parking_timer
    import parking_timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MINUTES = 99
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_1hz_in,
    input  logic             tick_2hz_in,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [MIN_W-1:0] limit_min,
    input  logic [SEC_W-1:0] limit_sec,
    output logic [MIN_W-1:0] elapsed_min,
    output logic [SEC_W-1:0] elapsed_sec,
    output logic [1:0]       state,
    output logic             sec_strobe,
    output logic             expired,
    output logic             blink
);

    localparam logic [MIN_W-1:0] MAX_MIN_C = MIN_W'(MAX_MINUTES);

    logic     strobe_1hz_s;
    state_e   state_q, state_d;
    elapsed_t cnt_q, cnt_d, cnt_inc_s;
    logic     expired_q, expired_d;
    logic     limit_set_s;
    logic     at_max_s;

    tick_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1hz (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_in (tick_1hz_in),
        .strobe  (strobe_1hz_s)
    );

    // Next-state and count: clear wins, then stop, then start; a strobe only
    // counts in RUNNING when no state-changing command shares its cycle.
    always_comb begin
        cnt_inc_s   = elapsed_inc(cnt_q);
        limit_set_s = (limit_min != 7'd0) || (limit_sec != 6'd0);
        at_max_s    = (cnt_q.min == MAX_MIN_C) && (cnt_q.sec == SEC_LAST);
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (clear) begin
            state_d   = ST_IDLE;
            cnt_d.min = 7'd0;
            cnt_d.sec = 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (start) begin
                        state_d = ST_RUNNING;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUNNING: begin
                    if (stop) begin
                        state_d = ST_PAUSED;
                    end else if (strobe_1hz_s) begin
                        if (at_max_s) begin
                            // Saturate: hold MAX:59 and expire whatever the limit.
                            state_d = ST_EXPIRED;
                        end else begin
                            cnt_d = cnt_inc_s;
                            // Equality only: a limit already passed never fires.
                            if (limit_set_s && (cnt_inc_s == {limit_min, limit_sec})) begin
                                state_d = ST_EXPIRED;
                            end else begin
                                state_d = ST_RUNNING;
                            end
                        end
                    end else begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_PAUSED: begin
                    if (stop) begin
                        state_d = ST_PAUSED;
                    end else if (start) begin
                        state_d = ST_RUNNING;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_d.min = 7'd0;
                    cnt_d.sec = 6'd0;
                end
            endcase
        end
        expired_d = (state_d == ST_EXPIRED);
    end

    // State, count and expired flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {7'd0, 6'd0};
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign elapsed_min = cnt_q.min;
    assign elapsed_sec = cnt_q.sec;
    assign state       = state_q;
    assign expired     = expired_q;
    assign sec_strobe  = strobe_1hz_s;

`ifdef PARKING_TIMER_BLINK_EN
    logic strobe_2hz_s;
    logic blink_q, blink_d;

    tick_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_2hz (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_in (tick_2hz_in),
        .strobe  (strobe_2hz_s)
    );

    // Blink toggles only while staying in EXPIRED; it starts low on entry and
    // drops to 0 the cycle EXPIRED is left.
    always_comb begin
        if ((state_q == ST_EXPIRED) && (state_d == ST_EXPIRED)) begin
            if (strobe_2hz_s) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
            end
        end else begin
            blink_d = 1'b0;
        end
    end

    // Blink register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    // The 2 Hz input has no consumer in this build.
    logic unused_tick_2hz_s;
    assign unused_tick_2hz_s = tick_2hz_in;
    assign blink             = 1'b0;
`endif

endmodule

// File: tb/tb_parking_timer.sv
module tb_parking_timer;
    import parking_timer_pkg::*;

    localparam int MAXM = 1;   // small saturation bound keeps the MAX:59 case short

    typedef struct {
        int         min;
        int         sec;
        logic [1:0] st;
    } exp_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   strobe_cnt;
    int   wide_cnt;
    logic prev_strobe;

    // bench model
    int         m_min;
    int         m_sec;
    logic [1:0] m_state;
    int         lm;
    int         ls;
    exp_t       sb[$];

    parking_timer_if bus ();

    parking_timer #(.SYNC_STAGES(2), .MAX_MINUTES(MAXM)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_1hz_in (bus.tick_1hz_in),
        .tick_2hz_in (bus.tick_2hz_in),
        .start       (bus.start),
        .stop        (bus.stop),
        .clear       (bus.clear),
        .limit_min   (bus.limit_min),
        .limit_sec   (bus.limit_sec),
        .elapsed_min (bus.elapsed_min),
        .elapsed_sec (bus.elapsed_sec),
        .state       (bus.state),
        .sec_strobe  (bus.sec_strobe),
        .expired     (bus.expired),
        .blink       (bus.blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe pulse counter and width monitor
    always @(negedge clk) begin
        if (bus.sec_strobe === 1'b1) begin
            strobe_cnt <= strobe_cnt + 1;
            if (prev_strobe === 1'b1) wide_cnt <= wide_cnt + 1;
        end
        prev_strobe <= bus.sec_strobe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, "_min"}, 32'(bus.elapsed_min), 32'(e.min));
        chk({tag, "_sec"}, 32'(bus.elapsed_sec), 32'(e.sec));
        chk({tag, "_state"}, 32'(bus.state), 32'(e.st));
        chk({tag, "_expired"}, 32'(bus.expired), (e.st == 2'd3) ? 32'd1 : 32'd0);
    endtask

    function automatic exp_t model_now();
        exp_t e;
        e.min = m_min;
        e.sec = m_sec;
        e.st  = m_state;
        return e;
    endfunction

    // model of one strobe; c: 0 none, 1 stop coincident, 2 start coincident
    task automatic model_strobe(input int c);
        if (c == 1) begin
            if (m_state == 2'd1) m_state = 2'd2;
        end else if (c == 2) begin
            if (m_state == 2'd0 || m_state == 2'd2) m_state = 2'd1;
        end else if (m_state == 2'd1) begin
            if (m_min == MAXM && m_sec == 59) begin
                m_state = 2'd3;
            end else begin
                if (m_sec == 59) begin
                    m_sec = 0;
                    m_min = m_min + 1;
                end else begin
                    m_sec = m_sec + 1;
                end
                if ((lm != 0 || ls != 0) && m_min == lm && m_sec == ls) m_state = 2'd3;
            end
        end
    endtask

    task automatic sec_edge(input int c);
        exp_t e;
        bit   seen;
        model_strobe(c);
        sb.push_back(model_now());
        @(negedge clk) bus.tick_1hz_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.sec_strobe === 1'b1) seen = 1'b1;
        end
        chk("strobe_seen", 32'(seen), 32'd1);
        if (c == 1) bus.stop = 1'b1;
        else if (c == 2) bus.start = 1'b1;
        @(negedge clk);
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        e = sb.pop_front();
        chk_out("edge", e);
        bus.tick_1hz_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // c: 0 clear, 1 stop, 2 start (no tick activity at the same time)
    task automatic do_cmd(input int c);
        @(negedge clk);
        if (c == 0) bus.clear = 1'b1;
        else if (c == 1) bus.stop = 1'b1;
        else bus.start = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        if (c == 0) begin
            m_state = 2'd0;
            m_min   = 0;
            m_sec   = 0;
        end else if (c == 1) begin
            if (m_state == 2'd1) m_state = 2'd2;
        end else begin
            if (m_state == 2'd0 || m_state == 2'd2) m_state = 2'd1;
        end
        chk_out("cmd", model_now());
    endtask

    task automatic set_limit(input int mn, input int sc);
        lm = mn;
        ls = sc;
        bus.limit_min = 7'(mn);
        bus.limit_sec = 6'(sc);
    endtask

    task automatic tick2(input logic exp_blink);
        @(negedge clk) bus.tick_2hz_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("blink", 32'(bus.blink), 32'(exp_blink));
        bus.tick_2hz_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int s0;
        total = 0; bad = 0; strobe_cnt = 0; wide_cnt = 0; prev_strobe = 1'b0;
        m_min = 0; m_sec = 0; m_state = 2'd0;
        bus.tick_1hz_in = 1'b0; bus.tick_2hz_in = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
        set_limit(0, 0);
        reset_n = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk_out("reset", model_now());
        chk("reset_strobe", 32'(bus.sec_strobe), 32'd0);
        chk("reset_blink", 32'(bus.blink), 32'd0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // 61 seconds -> 1:01, one-cycle strobes
        do_cmd(2);
        s0 = strobe_cnt;
        for (int i = 0; i < 61; i++) sec_edge(0);
        repeat (2) @(negedge clk);
        chk("strobes_61", 32'(strobe_cnt - s0), 32'd61);
        chk("strobe_width", 32'(wide_cnt), 32'd0);
        chk_out("t61", '{min: 1, sec: 1, st: 2'd1});
        do_cmd(0);

        // limit 0:05 -> expiry on 5th update, count then frozen
        set_limit(0, 5);
        do_cmd(2);
        for (int i = 0; i < 5; i++) sec_edge(0);
        chk_out("lim5", '{min: 0, sec: 5, st: 2'd3});
        for (int i = 0; i < 3; i++) sec_edge(0);
        do_cmd(1);
        do_cmd(2);
`ifdef PARKING_TIMER_BLINK_EN
        tick2(1'b1); tick2(1'b0); tick2(1'b1); tick2(1'b0);
        tick2(1'b1);
`else
        tick2(1'b0); tick2(1'b0); tick2(1'b0); tick2(1'b0);
`endif
        do_cmd(0);
        chk("clear_blink", 32'(bus.blink), 32'd0);
        set_limit(0, 0);

        // pause / resume, coincident stop and start are not counted
        do_cmd(2);
        for (int i = 0; i < 3; i++) sec_edge(0);
        do_cmd(1);
        for (int i = 0; i < 4; i++) sec_edge(0);
        do_cmd(2);
        for (int i = 0; i < 2; i++) sec_edge(0);
        chk_out("resume", '{min: 0, sec: 5, st: 2'd1});
        sec_edge(1);
        chk_out("stop_coinc", '{min: 0, sec: 5, st: 2'd2});
        sec_edge(2);
        chk_out("start_coinc", '{min: 0, sec: 5, st: 2'd1});
        // limit already behind the count: no expiry; limit ahead: expiry
        set_limit(0, 2);
        sec_edge(0);
        set_limit(0, 7);
        sec_edge(0);
        chk_out("lim_mid", '{min: 0, sec: 7, st: 2'd3});
        do_cmd(0);
        set_limit(0, 0);

        // tick high at reset release -> no strobe
        reset_n = 1'b0;
        bus.tick_1hz_in = 1'b1;
        repeat (3) @(negedge clk);
        s0 = strobe_cnt;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_strobe_at_release", 32'(strobe_cnt - s0), 32'd0);
        bus.tick_1hz_in = 1'b0;
        repeat (4) @(negedge clk);
        sec_edge(0);   // next real edge strobes in IDLE, count unchanged

        // reset mid-run at 0:42 acts immediately
        do_cmd(2);
        for (int i = 0; i < 42; i++) sec_edge(0);
        chk_out("at42", '{min: 0, sec: 42, st: 2'd1});
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk_out("async_reset", '{min: 0, sec: 0, st: 2'd0});
        m_min = 0; m_sec = 0; m_state = 2'd0;
        @(negedge clk) reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // saturation at MAX:59 expires without a limit
        do_cmd(2);
        for (int i = 0; i < 119; i++) sec_edge(0);
        chk_out("max59", '{min: MAXM, sec: 59, st: 2'd1});
        sec_edge(0);
        chk_out("sat", '{min: MAXM, sec: 59, st: 2'd3});
        sec_edge(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
